// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared APB/CSR types, CSR map bounds and bridge FSM states
package mvu_pkg;
   localparam int APB_ADDR_WIDTH = 15;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = 4;
   localparam int MVU_ID_WIDTH   = 3;

   typedef logic [11:0]               mvu_csr_t;
   typedef logic [APB_ADDR_WIDTH-1:0] apb_addr_t;
   typedef logic [APB_DATA_WIDTH-1:0] apb_data_t;
   typedef logic [APB_STRB_WIDTH-1:0] apb_strb_t;
   typedef logic [MVU_ID_WIDTH-1:0]   mvu_id_t;

   localparam mvu_csr_t CSR_FIRST      = 12'hF20;
   localparam mvu_csr_t CSR_LAST       = 12'hF69;
   localparam mvu_csr_t CSR_MVUSTATUS  = 12'hF54;
   localparam mvu_csr_t CSR_MVUCOMMAND = 12'hF55;

   typedef enum logic [1:0] {IDLE, LOCAL, REQ, RESP} bridge_state_t;

   function automatic logic csr_mapped(input mvu_csr_t csr);
      return (csr >= CSR_FIRST) && (csr <= CSR_LAST);
   endfunction
endpackage

// File: rtl/mvu_apb_csr_bridge_if.sv
// rtl/mvu_apb_csr_bridge_if.sv - host APB bus and per-MVU CSR request/ack bus
interface mvu_apb_if;
   import mvu_pkg::*;
   logic      psel;
   logic      penable;
   logic      pwrite;
   apb_addr_t paddr;
   apb_data_t pwdata;
   apb_strb_t pstrb;
   logic      pready;
   apb_data_t prdata;
   logic      pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                   input  pready, prdata, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                   output pready, prdata, pslverr);
endinterface

interface mvu_csr_if;
   import mvu_pkg::*;
   logic      csr_req;
   logic      csr_we;
   mvu_id_t   csr_mvu;
   mvu_csr_t  csr_addr;
   apb_data_t csr_wdata;
   apb_strb_t csr_wstrb;
   logic      csr_ack;
   apb_data_t csr_rdata;

   modport master (output csr_req, csr_we, csr_mvu, csr_addr, csr_wdata, csr_wstrb,
                   input  csr_ack, csr_rdata);
   modport slave  (input  csr_req, csr_we, csr_mvu, csr_addr, csr_wdata, csr_wstrb,
                   output csr_ack, csr_rdata);
endinterface

// File: rtl/mvu_busy_tracker.sv
// rtl/mvu_busy_tracker.sv - per-MVU busy flags, set by start and cleared by done
module mvu_busy_tracker #(
   parameter int NMVU = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NMVU-1:0] i_set,
   input  logic [NMVU-1:0] i_clr,
   output logic [NMVU-1:0] o_busy
);
   logic [NMVU-1:0] r_busy;

   // set dominates so a done arriving with its own start cannot lose the new job
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= i_set | (r_busy & ~i_clr);
   end

   assign o_busy = r_busy;
endmodule

// File: rtl/mvu_apb_csr_bridge.sv
// rtl/mvu_apb_csr_bridge.sv - APB slave forwarding CSR accesses to MVUs, local STATUS/busy
// Optional MVU_APB_SLVERR_EN: pslverr on unmapped and rejected-busy COMMAND accesses.
module mvu_apb_csr_bridge
   import mvu_pkg::*;
#(
   parameter int NMVU = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   mvu_apb_if.slave        apb,
   mvu_csr_if.master       csr,
   input  logic [NMVU-1:0] mvu_done,
   output logic [NMVU-1:0] mvu_start,
   output logic [NMVU-1:0] mvu_busy
);
   bridge_state_t   r_state, w_next;
   logic            r_we;
   mvu_id_t         r_mvu;
   mvu_csr_t        r_addr;
   apb_data_t       r_wdata;
   apb_strb_t       r_wstrb;
   apb_data_t       r_rdata;
   logic [NMVU-1:0] r_start;

   logic      w_setup, w_mapped, w_status_rd, w_cmd_busy, w_local, w_pready;
   mvu_id_t   w_id;
   mvu_csr_t  w_csr;
   apb_data_t w_local_rdata;

   assign w_setup     = apb.psel & ~apb.penable;
   assign w_id        = apb.paddr[14:12];
   assign w_csr       = apb.paddr[11:0];
   assign w_mapped    = csr_mapped(w_csr);
   assign w_status_rd = ~apb.pwrite & (w_csr == CSR_MVUSTATUS);
   assign w_cmd_busy  = apb.pwrite & (w_csr == CSR_MVUCOMMAND) & mvu_busy[w_id];
   assign w_local     = ~w_mapped | w_status_rd | w_cmd_busy;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_setup) w_next = w_local ? LOCAL : REQ;
         LOCAL:   w_next = IDLE;
         REQ:     if (csr.csr_ack) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_mvu   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_start <= '0;
      end else begin
         r_state <= w_next;
         r_start <= '0;
         if (r_state == IDLE && w_setup) begin
            r_we    <= apb.pwrite;
            r_mvu   <= w_id;
            r_addr  <= w_csr;
            r_wdata <= apb.pwdata;
            r_wstrb <= apb.pstrb;
         end
         if (r_state == REQ && csr.csr_ack) begin
            if (!r_we) r_rdata <= csr.csr_rdata;
            if (r_we && r_addr == CSR_MVUCOMMAND) r_start[r_mvu] <= 1'b1;
         end
      end
   end

`ifdef MVU_APB_SLVERR_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_err <= 1'b0;
      else if (r_state == IDLE && w_setup) r_err <= ~w_mapped | w_cmd_busy;
   end
   assign apb.pslverr = (r_state == LOCAL) & r_err;
`else
   assign apb.pslverr = 1'b0;
`endif

   // only STATUS is answered with data locally; unmapped reads return zero
   assign w_local_rdata = (r_addr == CSR_MVUSTATUS)
                        ? {{(APB_DATA_WIDTH-1){1'b0}}, mvu_busy[r_mvu]} : '0;
   assign w_pready      = (r_state == LOCAL) | (r_state == RESP);

   always_comb begin
      apb.prdata = '0;
      if (w_pready && !r_we) apb.prdata = (r_state == LOCAL) ? w_local_rdata : r_rdata;
   end

   assign apb.pready    = w_pready;
   assign csr.csr_req   = (r_state == REQ);
   assign csr.csr_we    = r_we;
   assign csr.csr_mvu   = r_mvu;
   assign csr.csr_addr  = r_addr;
   assign csr.csr_wdata = r_wdata;
   assign csr.csr_wstrb = r_wstrb;
   assign mvu_start     = r_start;

   mvu_busy_tracker #(.NMVU(NMVU)) u_busy (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_set  (r_start),
      .i_clr  (mvu_done),
      .o_busy (mvu_busy)
   );
endmodule
